// File: rtl/clint_timer.sv
// clint_timer: multi-hart machine timer and software-interrupt block.
// One 64-bit mtime counter advanced by a synchronised, prescaled rtc tick,
// NUM_HARTS 64-bit mtimecmp comparators and NUM_HARTS msip bits, all reached
// over the shared peripheral bus with a combinational read path.
//
// Optional build macro: CLINT_TIMER_HI_LATCH_EN
//   defined   - a read of mtime[31:0] snapshots mtime[63:32] into a shadow
//               register, and reads of mtime[63:32] return that snapshot.
//   undefined - mtime[63:32] reads return the live upper half.
module clint_timer #(
    parameter int NUM_HARTS = 1,
    parameter int ADDR_W    = 9,
    parameter int PRESC_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rtc,
    input  logic                 chip_select,
    input  logic                 addr_valid,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 op,
    input  logic                 data_valid,
    input  logic [31:0]          data_i,
    output wire logic            data_ready,
    output wire logic [31:0]     data_o,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip
);

    localparam logic [31:0] A_MTIME_LO = 32'h000;
    localparam logic [31:0] A_MTIME_HI = 32'h004;
    localparam logic [31:0] A_PRESC    = 32'h008;
    localparam logic [31:0] A_CTRL     = 32'h00C;
    localparam logic [31:0] A_CMP_BASE = 32'h010;
    localparam logic [31:0] A_MSIP     = 32'h100;

    logic [63:0]          mtime;
    logic [63:0]          mtimecmp [NUM_HARTS];
    logic [PRESC_W-1:0]   presc;
    logic [PRESC_W-1:0]   count;
    logic                 en;
    logic [NUM_HARTS-1:0] msip_r;

    logic                 rtc_s1;
    logic                 rtc_s2;
    logic                 rtc_q;
    logic                 tick;
    logic                 cnt_hit;
    logic                 inc;

    logic [31:0]          a32;
    logic                 wr_en;
    logic                 sel_mtime_lo;
    logic                 sel_mtime_hi;
    logic                 sel_presc;
    logic                 sel_ctrl;
    logic [NUM_HARTS-1:0] sel_cmp_lo;
    logic [NUM_HARTS-1:0] sel_cmp_hi;
    logic [NUM_HARTS-1:0] sel_msip;
    logic [31:0]          rdata;
    logic [31:0]          mtime_hi_rd;

    assign a32   = 32'(addr);
    assign wr_en = chip_select & addr_valid & op & data_valid;

    // Address decode; channels at or beyond NUM_HARTS never match.
    always_comb begin
        sel_mtime_lo = (a32 == A_MTIME_LO);
        sel_mtime_hi = (a32 == A_MTIME_HI);
        sel_presc    = (a32 == A_PRESC);
        sel_ctrl     = (a32 == A_CTRL);
        sel_cmp_lo   = '0;
        sel_cmp_hi   = '0;
        sel_msip     = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            sel_cmp_lo[i] = (a32 == A_CMP_BASE + 32'(8 * i));
            sel_cmp_hi[i] = (a32 == A_CMP_BASE + 32'(8 * i) + 32'h4);
            sel_msip[i]   = (a32 == A_MSIP + 32'(4 * i));
        end
    end

`ifdef CLINT_TIMER_HI_LATCH_EN
    logic        rd_lo;
    logic [31:0] mtime_hi_shadow;

    assign rd_lo = chip_select & addr_valid & ~op & sel_mtime_lo;

    // Snapshot the upper half on a lower-half read so a lo-then-hi pair is tear-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_hi_shadow <= '0;
        end else if (rd_lo) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end

    assign mtime_hi_rd = mtime_hi_shadow;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    // Read mux: unmapped addresses return zero.
    always_comb begin
        rdata = '0;
        if (sel_mtime_lo) rdata = mtime[31:0];
        if (sel_mtime_hi) rdata = mtime_hi_rd;
        if (sel_presc)    rdata = 32'(presc);
        if (sel_ctrl)     rdata = {31'd0, en};
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (sel_cmp_lo[i]) rdata = mtimecmp[i][31:0];
            if (sel_cmp_hi[i]) rdata = mtimecmp[i][63:32];
            if (sel_msip[i])   rdata = {31'd0, msip_r[i]};
        end
    end

    assign data_ready = chip_select ? addr_valid : 1'bz;
    assign data_o     = (chip_select & addr_valid) ? rdata : 32'bz;

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtc_s1 <= 1'b0;
            rtc_s2 <= 1'b0;
            rtc_q  <= 1'b0;
        end else begin
            rtc_s1 <= rtc;
            rtc_s2 <= rtc_s1;
            rtc_q  <= rtc_s2;
        end
    end

    // tick is high for exactly the clk cycle after the synchronised rise.
    assign tick    = rtc_s2 & ~rtc_q;
    assign cnt_hit = (count == presc);
    assign inc     = tick & en & cnt_hit;

    // Prescaler count: cleared by a PRESC write or while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if ((wr_en & sel_presc) | ~en) begin
            count <= '0;
        end else if (tick) begin
            count <= cnt_hit ? '0 : count + PRESC_W'(1);
        end
    end

    // mtime: a bus write to either half wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_en & sel_mtime_lo) begin
            mtime[31:0] <= data_i;
        end else if (wr_en & sel_mtime_hi) begin
            mtime[63:32] <= data_i;
        end else if (inc) begin
            mtime <= mtime + 64'd1;
        end
    end

    // PRESC and CTRL configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            en    <= 1'b1;
        end else if (wr_en) begin
            if (sel_presc) presc <= data_i[PRESC_W-1:0];
            if (sel_ctrl)  en    <= data_i[0];
        end
    end

    // Per-hart comparator values, written one 32-bit half at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                mtimecmp[i] <= '1;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                if (sel_cmp_lo[i]) mtimecmp[i][31:0]  <= data_i;
                if (sel_cmp_hi[i]) mtimecmp[i][63:32] <= data_i;
            end
        end
    end

    // Software interrupt bits; only bit0 of the write data is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_r <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                if (sel_msip[i]) msip_r[i] <= data_i[0];
            end
        end
    end

    // Registered compare; level stays up until mtime drops or mtimecmp rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtip <= '0;
        end else begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                mtip[i] <= (mtime >= mtimecmp[i]);
            end
        end
    end

    assign msip = msip_r;

endmodule

// File: tb/tb_clint_timer.sv
// Directed self-checking bench for clint_timer (four harts).
module tb_clint_timer;

    localparam int NH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rtc;
    logic          chip_select;
    logic          addr_valid;
    logic [8:0]    addr;
    logic          op;
    logic          data_valid;
    logic [31:0]   data_i;
    wire           data_ready;
    wire  [31:0]   data_o;
    wire  [NH-1:0] mtip;
    wire  [NH-1:0] msip;

    int checks_pass  = 0;
    int checks_total = 0;

    logic [31:0] rd;

    clint_timer #(.NUM_HARTS(NH), .ADDR_W(9), .PRESC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rtc         (rtc),
        .chip_select (chip_select),
        .addr_valid  (addr_valid),
        .addr        (addr),
        .op          (op),
        .data_valid  (data_valid),
        .data_i      (data_i),
        .data_ready  (data_ready),
        .data_o      (data_o),
        .mtip        (mtip),
        .msip        (msip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Combinational read inside the low phase; no clock edge is crossed.
    task automatic peek(input logic [8:0] a, output logic [31:0] d);
        chip_select = 1'b1;
        addr_valid  = 1'b1;
        op          = 1'b0;
        addr        = a;
        #1;
        d           = data_o;
        chip_select = 1'b0;
        addr_valid  = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [8:0] a, input logic [31:0] exp);
        logic [31:0] d;
        peek(a, d);
        check(tag, {32'd0, d}, {32'd0, exp});
    endtask

    // Read held across one rising edge (lets the shadow capture).
    task automatic bus_read(input logic [8:0] a, output logic [31:0] d);
        chip_select = 1'b1;
        addr_valid  = 1'b1;
        op          = 1'b0;
        addr        = a;
        #1;
        d           = data_o;
        @(posedge clk);
        #1;
        chip_select = 1'b0;
        addr_valid  = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
        chip_select = 1'b1;
        addr_valid  = 1'b1;
        op          = 1'b1;
        data_valid  = 1'b1;
        addr        = a;
        data_i      = d;
        @(posedge clk);
        #1;
        chip_select = 1'b0;
        addr_valid  = 1'b0;
        op          = 1'b0;
        data_valid  = 1'b0;
        @(negedge clk);
    endtask

    task automatic rtc_pulse();
        rtc = 1'b1;
        repeat (3) @(negedge clk);
        rtc = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        rtc         = 1'b0;
        chip_select = 1'b0;
        addr_valid  = 1'b0;
        op          = 1'b0;
        data_valid  = 1'b0;
        addr        = '0;
        data_i      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk_rd("rst_mtime_lo", 9'h000, 32'h0);
        chk_rd("rst_mtime_hi", 9'h004, 32'h0);
        chk_rd("rst_cmp0_lo",  9'h010, 32'hFFFF_FFFF);
        chk_rd("rst_cmp0_hi",  9'h014, 32'hFFFF_FFFF);
        chk_rd("rst_presc",    9'h008, 32'h0);
        chk_rd("rst_ctrl",     9'h00C, 32'h1);
        check("rst_mtip", {60'd0, mtip}, 64'h0);
        check("rst_msip", {60'd0, msip}, 64'h0);
        chip_select = 1'b1;
        addr_valid  = 1'b1;
        #1;
        check("data_ready", {63'd0, data_ready}, 64'h1);
        chip_select = 1'b0;
        addr_valid  = 1'b0;

        // PRESC=3: increments on 4th and 8th tick, three edges after rtc rise
        bus_write(9'h008, 32'h3);
        chk_rd("presc_rb", 9'h008, 32'h3);
        for (int k = 1; k <= 8; k++) begin
            rtc = 1'b1;
            repeat (2) @(negedge clk);
            peek(9'h000, rd);
            check($sformatf("presc_pre_%0d", k), {32'd0, rd}, 64'((k - 1) / 4));
            @(negedge clk);
            peek(9'h000, rd);
            check($sformatf("presc_post_%0d", k), {32'd0, rd}, 64'(k / 4));
            rtc = 1'b0;
            repeat (3) @(negedge clk);
        end

        // Comparators: cmp[1]=5, cmp[0]=10
        bus_write(9'h008, 32'h0);
        bus_write(9'h000, 32'h0);
        bus_write(9'h004, 32'h0);
        bus_write(9'h018, 32'd5);
        bus_write(9'h01C, 32'd0);
        bus_write(9'h010, 32'd10);
        bus_write(9'h014, 32'd0);
        check("mtip_before", {60'd0, mtip}, 64'h0);
        repeat (6) rtc_pulse();
        chk_rd("mtime_6", 9'h000, 32'd6);
        check("mtip_6", {60'd0, mtip}, 64'b0010);
        repeat (4) rtc_pulse();
        chk_rd("mtime_10", 9'h000, 32'd10);
        check("mtip_10", {60'd0, mtip}, 64'b0011);
        bus_write(9'h01C, 32'd1);
        check("mtip_clr_lat0", {60'd0, mtip}, 64'b0011);
        @(negedge clk);
        check("mtip_clr_lat1", {60'd0, mtip}, 64'b0001);

        // 64-bit wrap
        bus_write(9'h000, 32'hFFFF_FFFF);
        bus_write(9'h004, 32'hFFFF_FFFF);
        rtc_pulse();
        chk_rd("wrap_lo", 9'h000, 32'h0);
        chk_rd("wrap_hi", 9'h004, 32'h0);
        check("wrap_mtip", {60'd0, mtip}, 64'b0000);

        // Write on the tick edge: written value wins, increment dropped
        rtc = 1'b1;
        repeat (2) @(negedge clk);
        bus_write(9'h000, 32'h10);
        rtc = 1'b0;
        repeat (3) @(negedge clk);
        chk_rd("collide_lo", 9'h000, 32'h10);
        chk_rd("collide_hi", 9'h004, 32'h0);

        // en=0 freezes mtime
        bus_write(9'h00C, 32'hFFFF_FFFE);
        chk_rd("ctrl_off", 9'h00C, 32'h0);
        rtc_pulse();
        chk_rd("frozen", 9'h000, 32'h10);
        bus_write(9'h00C, 32'h1);
        rtc_pulse();
        chk_rd("resumed", 9'h000, 32'h11);

        // MSIP and out-of-range channels
        bus_write(9'h108, 32'hFFFF_FFFF);
        check("msip_2", {60'd0, msip}, 64'b0100);
        chk_rd("msip_2_rb", 9'h108, 32'h1);
        bus_write(9'h114, 32'hFFFF_FFFF);
        check("msip_5_ign", {60'd0, msip}, 64'b0100);
        chk_rd("msip_5_rd", 9'h114, 32'h0);
        bus_write(9'h030, 32'h1234_5678);
        chk_rd("unmapped_cmp4", 9'h030, 32'h0);

        // Tear-free upper half (shadow) versus live read
        bus_write(9'h000, 32'hFFFF_FFFF);
        bus_write(9'h004, 32'h0);
        bus_read(9'h000, rd);
        check("shadow_lo", {32'd0, rd}, 64'h0000_0000_FFFF_FFFF);
        rtc_pulse();
`ifdef CLINT_TIMER_HI_LATCH_EN
        chk_rd("shadow_hi", 9'h004, 32'h0);
`else
        chk_rd("shadow_hi", 9'h004, 32'h1);
`endif
        chk_rd("post_lo", 9'h000, 32'h0);
        bus_read(9'h000, rd);
        chk_rd("relatch_hi", 9'h004, 32'h1);

        // Reset in the middle of a write
        chip_select = 1'b1;
        addr_valid  = 1'b1;
        op          = 1'b1;
        data_valid  = 1'b1;
        addr        = 9'h100;
        data_i      = 32'h1;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        chip_select = 1'b0;
        addr_valid  = 1'b0;
        op          = 1'b0;
        data_valid  = 1'b0;
        check("midrst_msip", {60'd0, msip}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_rd("midrst_mtime_lo", 9'h000, 32'h0);
        chk_rd("midrst_cmp1_hi",  9'h01C, 32'hFFFF_FFFF);
        chk_rd("midrst_ctrl",     9'h00C, 32'h1);
        chk_rd("midrst_msip0",    9'h100, 32'h0);
        check("midrst_mtip", {60'd0, mtip}, 64'h0);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
